// File: rtl/wb_stage.sv
// MIPS write-back stage: MEM/WB pipeline register followed by the MemtoReg mux.
// The outputs depend only on the registered values, so inputs reach them one clock later.
module wb_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [DATA_WIDTH-1:0]     outputMux,
  output logic [REG_ADDR_WIDTH-1:0] RegwriteOut,
  output logic                      PCSrcout,
  input  logic                      PCSrcin,
  input  logic [REG_ADDR_WIDTH-1:0] RegWriteIn,
  input  logic [DATA_WIDTH-1:0]     input1,
  input  logic [DATA_WIDTH-1:0]     input0,
  input  logic                      select
);

  logic [DATA_WIDTH-1:0]     input0_q, input0_d;
  logic [DATA_WIDTH-1:0]     input1_q, input1_d;
  logic                      select_q, select_d;
  logic [REG_ADDR_WIDTH-1:0] regWrite_q, regWrite_d;
  logic                      pcSrc_q, pcSrc_d;

  // No enable or stall: the register loads every cycle.
  always_comb begin
    input0_d   = input0;
    input1_d   = input1;
    select_d   = select;
    regWrite_d = RegWriteIn;
    pcSrc_d    = PCSrcin;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      input0_q   <= '0;
      input1_q   <= '0;
      select_q   <= 1'b0;
      regWrite_q <= '0;
      pcSrc_q    <= 1'b0;
    end else begin
      input0_q   <= input0_d;
      input1_q   <= input1_d;
      select_q   <= select_d;
      regWrite_q <= regWrite_d;
      pcSrc_q    <= pcSrc_d;
    end
  end

  // A ternary keeps the unselected operand out of the result entirely.
  assign outputMux   = select_q ? input1_q : input0_q;
  assign RegwriteOut = regWrite_q;
  assign PCSrcout    = pcSrc_q;

endmodule

// File: tb/tb_wb_stage.sv
// Randomized and directed checks of wb_stage against a one-cycle-latency write-back model.
module tb_wb_stage;

  logic        clk;
  logic        rst;
  logic [31:0] outputMux;
  logic [4:0]  RegwriteOut;
  logic        PCSrcout;
  logic        PCSrcin;
  logic [4:0]  RegWriteIn;
  logic [31:0] input1;
  logic [31:0] input0;
  logic        select;

  int assertCount  = 0;
  int failureCount = 0;

  // Model state: what the outputs should show after the most recent edge.
  logic [31:0] expMux;
  logic [4:0]  expReg;
  logic        expPc;
  bit          resetSeen = 0;

  wb_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .outputMux  (outputMux),
    .RegwriteOut(RegwriteOut),
    .PCSrcout   (PCSrcout),
    .PCSrcin    (PCSrcin),
    .RegWriteIn (RegWriteIn),
    .input1     (input1),
    .input0     (input0),
    .select     (select)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failureCount++;
      $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, confirm outputs still hold the previous value
  // before the edge, then confirm the new value just after the edge.
  task automatic applyStimulus(input logic r, input logic sel, input logic [31:0] in0,
                               input logic [31:0] in1, input logic [4:0] regIn, input logic pcIn);
    @(negedge clk);
    rst = r; select = sel; input0 = in0; input1 = in1; RegWriteIn = regIn; PCSrcin = pcIn;
    #5;
    if (resetSeen) begin
      checkOutput("holdMux", outputMux, expMux);
      checkOutput("holdReg", {27'd0, RegwriteOut}, {27'd0, expReg});
      checkOutput("holdPc", {31'd0, PCSrcout}, {31'd0, expPc});
    end
    @(posedge clk);
    if (r) begin
      expMux = 32'd0; expReg = 5'd0; expPc = 1'b0;
      resetSeen = 1;
    end else begin
      expMux = sel ? in1 : in0;
      expReg = regIn;
      expPc  = pcIn;
    end
    #1;
    if (resetSeen) begin
      checkOutput("outputMux", outputMux, expMux);
      checkOutput("RegwriteOut", {27'd0, RegwriteOut}, {27'd0, expReg});
      checkOutput("PCSrcout", {31'd0, PCSrcout}, {31'd0, expPc});
    end
  endtask

  logic [31:0] aluVals [9] = '{32'h002300AA, 32'h10654321, 32'h00100022, 32'h8C123456,
                               32'h8F123456, 32'hAD654321, 32'h13012345, 32'hAC654321,
                               32'h12012345};

  initial begin
    rst = 1'b1; select = 1'b0; input0 = '0; input1 = '0; RegWriteIn = '0; PCSrcin = 1'b0;

    // Reset held for two edges with nonzero inputs.
    applyStimulus(1'b1, 1'b0, 32'h002300AA, 32'h0, 5'd7, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h002300AA, 32'h0, 5'd7, 1'b1);

    // ALU path.
    for (int i = 0; i < 9; i++)
      applyStimulus(1'b0, 1'b0, aluVals[i], 32'h0, 5'd0, 1'b0);

    // select flips to 1 while input1 is 0.
    applyStimulus(1'b0, 1'b1, 32'h12012345, 32'h0, 5'd0, 1'b0);

    // Memory path.
    for (int i = 1; i < 9; i++)
      applyStimulus(1'b0, 1'b1, 32'h12012345, aluVals[i], 5'd0, 1'b0);

    // Register number and branch flag pass-through, under both select values.
    applyStimulus(1'b0, 1'b0, 32'h0000FFFF, 32'hFFFF0000, 5'd31, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h0000FFFF, 32'hFFFF0000, 5'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h0000FFFF, 32'hFFFF0000, 5'd31, 1'b1);

    // Mid-operation reset with all-ones data.
    applyStimulus(1'b0, 1'b1, 32'h0, 32'hFFFFFFFF, 5'd5, 1'b1);
    applyStimulus(1'b1, 1'b1, 32'h0, 32'hFFFFFFFF, 5'd5, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h0, 32'hFFFFFFFF, 5'd5, 1'b1);

    // Unselected input driven to X.
    applyStimulus(1'b0, 1'b0, 32'h00000001, 32'hxxxxxxxx, 5'd3, 1'b0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 300; i++)
      applyStimulus(($urandom_range(0, 19) == 0), $urandom_range(0, 1), $urandom, $urandom,
                    5'($urandom_range(0, 31)), $urandom_range(0, 1));

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failureCount);
    $finish;
  end

  initial begin
    #1ms;
    $display("[TB] FAIL timeout: simulation did not complete, observed running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
